// File: rtl/tdc_word_serializer.sv
// -----------------------------------------------------------------------------
// tdc_word_serializer
//
// Pops 48-bit TDC timestamp words from a FIFO and sends each one, MSB byte
// first, over a valid/ready byte interface toward the UART/host transmitter.
// The FIFO read port has one cycle of registered read latency, so a word moves
// through IDLE -> POP -> LOAD -> SEND. Only one pop is outstanding at a time:
// the next word is requested only after the current one has fully gone out.
//
// Optional feature (compile-time macro TDC_SER_CHECKSUM_EN):
//   defined   - an extra byte, the XOR of the data bytes, is sent after the
//               last data byte. word_count counts the word only once that
//               checksum byte has been accepted.
//   undefined - exactly NBYTES bytes per word; no checksum accumulator exists.
//
// Parameters:
//   WORD_W  FIFO word width, a multiple of 8 (default 48)
//   CNT_W   width of the sent-word counter (default 16)
//
// Ports:
//   clk         system clock, everything on posedge
//   rst         synchronous active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO registered read data, valid the cycle after a pop
//   fifo_rd_en  registered FIFO pop strobe (one-cycle pulse)
//   tx_data     byte toward the transmitter
//   tx_valid    tx_data is valid
//   tx_ready    transmitter accepts the byte this cycle
//   busy        high whenever the serializer is not in IDLE
//   word_count  number of fully transmitted words, wraps silently
// -----------------------------------------------------------------------------
module tdc_word_serializer #(
    parameter int WORD_W = 48,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  word_count
);

    localparam int NBYTES = WORD_W / 8;
`ifdef TDC_SER_CHECKSUM_EN
    localparam int NSEND  = NBYTES + 1;
`else
    localparam int NSEND  = NBYTES;
`endif
    localparam int IDX_W  = (NSEND > 1) ? $clog2(NSEND) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEND - 1);
`ifdef TDC_SER_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(NBYTES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_LOAD = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic                fifo_rd_en_r;
    logic [7:0]          tx_data_r;
    logic                tx_valid_r;
    logic                busy_r;
    logic [CNT_W-1:0]    word_count_r;
    logic [WORD_W-1:0]   shift_r;
    logic [IDX_W-1:0]    byte_idx_r;
    logic                xfer_s;
    logic                last_s;
    logic [WORD_W-1:0]   shifted_s;
    logic [7:0]          next_byte_s;
`ifdef TDC_SER_CHECKSUM_EN
    logic [7:0]          csum_r;
`endif

    // Next-state decode plus the byte that follows a non-final transfer.
    always_comb begin
        next_state_s = state_r;
        xfer_s       = tx_valid_r && tx_ready;
        last_s       = (byte_idx_r == LAST_IDX);
        shifted_s    = shift_r << 8;
        next_byte_s  = shifted_s[WORD_W-1 -: 8];
`ifdef TDC_SER_CHECKSUM_EN
        // After the last data byte the checksum goes out; fold in the byte
        // currently on the bus since the accumulator has not seen it yet.
        if (byte_idx_r == LAST_DATA_IDX) begin
            next_byte_s = csum_r ^ tx_data_r;
        end else begin
            next_byte_s = shifted_s[WORD_W-1 -: 8];
        end
`endif
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    next_state_s = ST_POP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_POP:  next_state_s = ST_LOAD;
            ST_LOAD: next_state_s = ST_SEND;
            ST_SEND: begin
                if (xfer_s && last_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register, registered outputs and the word datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            fifo_rd_en_r <= 1'b0;
            tx_data_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            word_count_r <= {CNT_W{1'b0}};
            shift_r      <= {WORD_W{1'b0}};
            byte_idx_r   <= {IDX_W{1'b0}};
`ifdef TDC_SER_CHECKSUM_EN
            csum_r       <= 8'h00;
`endif
        end else begin
            state_r      <= next_state_s;
            busy_r       <= (next_state_s != ST_IDLE);
            // The pop strobe is high only for the cycle spent in POP.
            fifo_rd_en_r <= (state_r == ST_IDLE) && !fifo_empty;
            case (state_r)
                ST_LOAD: begin
                    shift_r    <= fifo_data;
                    tx_data_r  <= fifo_data[WORD_W-1 -: 8];
                    tx_valid_r <= 1'b1;
                    byte_idx_r <= {IDX_W{1'b0}};
`ifdef TDC_SER_CHECKSUM_EN
                    csum_r     <= 8'h00;
`endif
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        if (last_s) begin
                            tx_valid_r   <= 1'b0;
                            word_count_r <= word_count_r + CNT_W'(1);
                        end else begin
                            shift_r    <= shifted_s;
                            tx_data_r  <= next_byte_s;
                            byte_idx_r <= byte_idx_r + IDX_W'(1);
`ifdef TDC_SER_CHECKSUM_EN
                            csum_r     <= csum_r ^ tx_data_r;
`endif
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fifo_rd_en = fifo_rd_en_r;
    assign tx_data    = tx_data_r;
    assign tx_valid   = tx_valid_r;
    assign busy       = busy_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_tdc_word_serializer.sv
`timescale 1ns/1ps
module tb_tdc_word_serializer;

    localparam int WORD_W = 48;
    localparam int CNT_W  = 16;
    localparam int NBYTES = WORD_W / 8;
`ifdef TDC_SER_CHECKSUM_EN
    localparam int WORD_CYC = 10;
`else
    localparam int WORD_CYC = 9;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_data;
    logic              fifo_rd_en;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic [CNT_W-1:0]  word_count;

    // second instance with a narrow counter so the wrap is reachable quickly
    logic              w_empty = 1'b0;
    logic [WORD_W-1:0] w_data  = 48'hFEDC_BA98_7654;
    logic              w_ready = 1'b1;
    logic              w_rd_en;
    logic [7:0]        w_tx_data;
    logic              w_tx_valid;
    logic              w_busy;
    logic [2:0]        w_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]        exp_q[$];
    logic [WORD_W-1:0] fifo_q[$];

    always #5 clk = ~clk;

    tdc_word_serializer #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .word_count(word_count)
    );

    tdc_word_serializer #(.WORD_W(WORD_W), .CNT_W(3)) dut_wrap (
        .clk(clk), .rst(rst), .fifo_empty(w_empty), .fifo_data(w_data),
        .fifo_rd_en(w_rd_en), .tx_data(w_tx_data), .tx_valid(w_tx_valid),
        .tx_ready(w_ready), .busy(w_busy), .word_count(w_count)
    );

    always @(posedge clk) cyc++;

    // FIFO model: registered read data, pop sampled on the clock edge
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL pop_when_empty: rd_en=1 with FIFO model empty at cycle %0d", cyc);
            end else begin
                fifo_data <= fifo_q.pop_front();
            end
        end
    end

    always @(negedge clk) fifo_empty = (fifo_q.size() == 0);

    // Monitor / scoreboard state
    int         xfer_cnt = 0;
    int         rd_pulses = 0;
    int         last_rd_cyc = -100;
    bit         rd_prev = 1'b0;
    bit         tv_prev = 1'b0;
    bit         hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;
    bit         gap_chk = 1'b0;
    bit         gap_ref = 1'b0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (!rst) begin
            if (hold_pend) begin
                checks++;
                if (!tx_valid || tx_data !== hold_data) begin
                    errors++;
                    $display("FAIL hold: valid=%0b data=%02h, required valid=1 data=%02h", tx_valid, tx_data, hold_data);
                end
            end
            if (fifo_rd_en) begin
                checks++;
                if (rd_prev) begin
                    errors++;
                    $display("FAIL rd_en_width: rd_en high two cycles in a row at cycle %0d", cyc);
                end
                if (gap_chk) begin
                    if (gap_ref) begin
                        checks++;
                        if (cyc - last_rd_cyc != WORD_CYC) begin
                            errors++;
                            $display("FAIL pop_gap: %0d cycles, required %0d", cyc - last_rd_cyc, WORD_CYC);
                        end
                    end
                    gap_ref = 1'b1;
                end
                last_rd_cyc = cyc;
                rd_pulses++;
            end
            if (tx_valid && !tv_prev) begin
                checks++;
                if (cyc - last_rd_cyc != 2) begin
                    errors++;
                    $display("FAIL first_byte_latency: %0d cycles after pop, required 2", cyc - last_rd_cyc);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %02h, none expected", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (tx_data !== exp_b) begin
                        errors++;
                        $display("FAIL byte: got %02h, required %02h", tx_data, exp_b);
                    end
                end
                xfer_cnt++;
            end
            hold_pend = tx_valid && !tx_ready;
            hold_data = tx_data;
        end else begin
            hold_pend = 1'b0;
        end
        rd_prev = fifo_rd_en;
        tv_prev = tx_valid;
    end

    // Wrap-instance monitor: each change of the 3-bit counter is +1 mod 8
    logic [2:0] w_prev = 3'd0;
    int         wraps = 0;
    always @(negedge clk) begin
        if (!rst && w_count !== w_prev) begin
            checks++;
            if (w_count !== w_prev + 3'd1) begin
                errors++;
                $display("FAIL wrap_step: count %0d after %0d", w_count, w_prev);
            end
            if (w_count == 3'd0) wraps++;
        end
        w_prev = (rst) ? 3'd0 : w_count;
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        for (int i = NBYTES - 1; i >= 0; i--) begin
            b = w[i*8 +: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
`ifdef TDC_SER_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
        fifo_q.push_back(w);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((exp_q.size() != 0 || busy || fifo_q.size() != 0) && n < 2000);
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
        end
    endtask

    int start;
    int pulses0;
    int n;
    logic [7:0] t2_bytes [7];

    initial begin
        rst = 1'b1;
        tx_ready = 1'b1;
        fifo_data = '0;
        fifo_empty = 1'b1;

        // 1. reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check_eq("idle_rd_en", 64'(fifo_rd_en), 64'd0);
            check_eq("idle_tx_valid", 64'(tx_valid), 64'd0);
            check_eq("idle_busy", 64'(busy), 64'd0);
            check_eq("idle_word_count", 64'(word_count), 64'd0);
            check_eq("idle_tx_data", 64'(tx_data), 64'd0);
        end

        // 2. single word, hand-computed byte table
        t2_bytes[0] = 8'h01; t2_bytes[1] = 8'h23; t2_bytes[2] = 8'h45;
        t2_bytes[3] = 8'h67; t2_bytes[4] = 8'h89; t2_bytes[5] = 8'hAB;
        t2_bytes[6] = 8'h22;
        pulses0 = rd_pulses;
        for (int i = 0; i < NBYTES; i++) exp_q.push_back(t2_bytes[i]);
`ifdef TDC_SER_CHECKSUM_EN
        exp_q.push_back(t2_bytes[6]);
`endif
        fifo_q.push_back(48'h0123_4567_89AB);
        wait_done("single");
        check_eq("single_pops", 64'(rd_pulses - pulses0), 64'd1);
        check_eq("single_word_count", 64'(word_count), 64'd1);

        // 3. backpressure on byte 0x45
        push_word(48'h0123_4567_89AB);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(tx_valid && tx_data == 8'h45) && n < 100);
        check_eq("bp_reach_45", 64'(n < 100), 64'd1);
        tx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_done("backpressure");
        check_eq("bp_word_count", 64'(word_count), 64'd2);

        // 4. back-to-back words
        pulses0 = rd_pulses;
        gap_ref = 1'b0;
        gap_chk = 1'b1;
        for (int i = 0; i < 4; i++) push_word(48'hAAAA_AAAA_AAA0 + 48'(i));
        wait_done("b2b");
        gap_chk = 1'b0;
        check_eq("b2b_pops", 64'(rd_pulses - pulses0), 64'd4);
        check_eq("b2b_word_count", 64'(word_count), 64'd6);

        // 5. reset after the third byte transfers
        start = xfer_cnt;
        push_word(48'h1122_3344_5566);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (xfer_cnt < start + 3 && n < 100);
        check_eq("rst_reach_byte3", 64'(n < 100), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_word_count", 64'(word_count), 64'd0);
        check_eq("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        rst = 1'b0;
        push_word(48'h8899_AABB_CCDD);
        wait_done("after_rst");
        check_eq("after_rst_word_count", 64'(word_count), 64'd1);

        // 6. wrap: narrow-counter instance has been streaming the whole time
        repeat (100) @(posedge clk);
        #1;
        check_eq("wrap_seen", 64'(wraps > 0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
